// File: rtl/game_state_ctrl.sv
// Game flow controller: debounced start button, per-player scoring, win-screen hold
// and a one-cycle restart pulse to the gameplay logic on every new game.
module game_state_ctrl #(
  parameter int WIN_SCORE       = 5,
  parameter int SCORE_W         = 4,
  parameter int WIN_HOLD_FRAMES = 300,
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               vsync,
  input  logic               p1_point,
  input  logic               p2_point,
  output logic [1:0]         screen,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               game_rst
);

  // Encodings match the screen_selector state enum: START, GAME, PLAYER_1, PLAYER_2.
  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_GAME  = 2'd1;
  localparam logic [1:0] ST_P1    = 2'd2;
  localparam logic [1:0] ST_P2    = 2'd3;

  localparam int HOLD_W = (WIN_HOLD_FRAMES < 1) ? 1 : $clog2(WIN_HOLD_FRAMES + 1);
  localparam int DB_W   = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(WIN_HOLD_FRAMES - 1);
  localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               db_level_q, db_level_d;
  logic               vsync_q, vsync_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [1:0]         screen_q, screen_d;
  logic [SCORE_W-1:0] score_p1_q, score_p1_d;
  logic [SCORE_W-1:0] score_p2_q, score_p2_d;
  logic               game_rst_q, game_rst_d;

  logic               press;
  logic               frame_tick;
  logic [SCORE_W-1:0] p1_inc;
  logic [SCORE_W-1:0] p2_inc;

  // Button path: two-flop synchroniser, then a stability counter against the accepted level.
  always_comb begin
    sync1_d    = btn_start;
    sync2_d    = sync1_q;
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    press      = 1'b0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync2_q;
        press      = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign vsync_d    = vsync;
  assign frame_tick = vsync & ~vsync_q;

  assign p1_inc = score_p1_q + SCORE_W'(1);
  assign p2_inc = score_p2_q + SCORE_W'(1);

  always_comb begin
    screen_d   = screen_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    hold_d     = hold_q;
    game_rst_d = 1'b0;
    case (screen_q)
      ST_START: begin
        hold_d = '0;
        if (press) begin
          screen_d   = ST_GAME;
          score_p1_d = '0;
          score_p2_d = '0;
          game_rst_d = 1'b1;
        end
      end
      ST_GAME: begin
        hold_d = '0;
        // p1 wins ties; a simultaneous p2 pulse is dropped.
        if (p1_point) begin
          if (p1_inc >= WIN_S) begin
            score_p1_d = WIN_S;
            screen_d   = ST_P1;
          end else begin
            score_p1_d = p1_inc;
          end
        end else if (p2_point) begin
          if (p2_inc >= WIN_S) begin
            score_p2_d = WIN_S;
            screen_d   = ST_P2;
          end else begin
            score_p2_d = p2_inc;
          end
        end
      end
      ST_P1, ST_P2: begin
        if (press) begin
          screen_d = ST_START;
          hold_d   = '0;
        end else if (frame_tick) begin
          if (hold_q >= HOLD_LAST) begin
            screen_d = ST_START;
            hold_d   = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        screen_d = ST_START;
        hold_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      vsync_q    <= 1'b0;
      hold_q     <= '0;
      screen_q   <= ST_START;
      score_p1_q <= '0;
      score_p2_q <= '0;
      game_rst_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      vsync_q    <= vsync_d;
      hold_q     <= hold_d;
      screen_q   <= screen_d;
      score_p1_q <= score_p1_d;
      score_p2_q <= score_p2_d;
      game_rst_q <= game_rst_d;
    end
  end

  assign screen   = screen_q;
  assign score_p1 = score_p1_q;
  assign score_p2 = score_p2_q;
  assign game_rst = game_rst_q;

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level game flow controller that produces the `screen` selection (vga_pkg `state` enum: START, GAME, PLAYER_1, PLAYER_2) consumed directly by screen_selector.
- Debounces the start button, counts points per player, and declares a winner.
- Holds the win screen for a fixed number of frames, then returns to START.
- Issues a one-cycle game-restart pulse to the gameplay logic.

Parameters:
- WIN_SCORE, 5, points needed to win; scores saturate here.
- SCORE_W, 4, width of score outputs; must satisfy WIN_SCORE <= 2**SCORE_W-1.
- WIN_HOLD_FRAMES, 300, number of vsync frames the win screen is held (5 s at 60 Hz).
- DEBOUNCE_CYCLES, 650000, number of clk cycles the synchronised button level must stay stable before it is accepted.

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- btn_start  in  1  raw start button, asynchronous to clk
- vsync  in  1  vsync from the timing chain, synchronous to clk
- p1_point  in  1  single-cycle pulse: player 1 scored
- p2_point  in  1  single-cycle pulse: player 2 scored
- screen  out  state  current screen, registered
- score_p1  out  SCORE_W  player 1 score, registered
- score_p2  out  SCORE_W  player 2 score, registered
- game_rst  out  1  single-cycle pulse on entry to GAME

Behaviour:
- Reset (rst=0, asynchronous):
  - screen=START, score_p1=0, score_p2=0, game_rst=0.
  - Synchroniser, debounce counter, debounced level, vsync edge register and hold counter all cleared.
  - Reset mid-game or mid-hold aborts immediately; the first cycle after release behaves as a fresh START.
- Button path:
  - 2-FF synchroniser, then debounce. The counter increments while the synchronised level differs from the debounced level and clears otherwise.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronised value.
  - `press` is a one-cycle pulse on the debounced 0->1 edge. Releases produce no event.
- Frame tick: one-cycle pulse on the vsync 0->1 edge (previous vsync registered).
- FSM, one transition per cycle; all outputs update on the clock edge after the triggering input cycle:
  - START:
    - press -> GAME; same edge: score_p1=0, score_p2=0, game_rst=1 for exactly one cycle.
    - Point pulses ignored.
  - GAME:
    - p1_point increments score_p1. If the new value equals WIN_SCORE -> PLAYER_1 on the same edge.
    - p2_point, when p1_point is low, behaves the same for score_p2 -> PLAYER_2.
    - p1_point and p2_point in the same cycle: p1 has priority, the p2 pulse is discarded.
    - press ignored.
  - PLAYER_1 / PLAYER_2:
    - Hold counter cleared on entry; increments on each frame tick.
    - When the counter reaches WIN_HOLD_FRAMES-1 and a frame tick occurs -> START.
    - press -> START immediately, with priority over the tick.
    - Scores are retained, so the final score stays visible. Point pulses ignored.
  - Any illegal encoding -> START.
- Arithmetic:
  - Scores never exceed WIN_SCORE and never wrap.
  - The hold counter is sized $clog2(WIN_HOLD_FRAMES+1) and never wraps.
- game_rst is asserted only on the START->GAME edge and is never asserted during reset.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, WIN_SCORE=3, WIN_HOLD_FRAMES=2):
- Reset/start:
  - Stimulus: rst low, then released; btn_start held high for 10 cycles.
  - Required: screen=START and scores 0 during reset. Exactly one game_rst pulse, coincident with screen becoming GAME. A 2-cycle glitch on btn_start produces no transition.
- Player 1 win:
  - Stimulus: in GAME, three p1_point pulses.
  - Required: score_p1 goes 1, 2, 3. screen=PLAYER_1 on the edge after the third pulse. Further pulses leave the score at 3.
- Simultaneous points:
  - Stimulus: in GAME with score 2:2, p1_point and p2_point high in the same cycle.
  - Required: score_p1=3, score_p2=2, screen=PLAYER_1.
- Win hold timeout:
  - Stimulus: in PLAYER_2, toggle vsync to produce two rising edges.
  - Required: screen=START one cycle after the second edge; scores still show the final values. A later press clears the scores to 0:0 and enters GAME.
- Early exit and reset abort:
  - Stimulus: press during PLAYER_1 before any frame tick.
  - Required: screen=START immediately.
  - Stimulus: rst asserted during GAME with score 1:2.
  - Required: outputs go asynchronously to START and 0:0, with game_rst=0.
- Ignored inputs:
  - Stimulus: point pulses in START, and a press in GAME.
  - Required: no score change, no screen change, no game_rst.
